divmod_seq: RTL
===============

// Module: divmod_seq
// PURPOSE
//   Parametrised sequential integer divider returning quotient and remainder of a / b.
//   Successor to the repeated-subtraction modulo unit: fixed latency (one quotient bit
//   per cycle, restoring shift-subtract), selectable signed/unsigned mode, divide-by-zero flag.
//   Sits beside the ALU as a multi-cycle functional unit under start/done handshake.
// PARAMETERS
//   WIDTH      32  operand/result width in bits (>= 2)
//   SIGNED_EN  1   1: is_signed honoured; 0: is_signed ignored, always unsigned
// PORTS
//   clk          in   1      clock, all state updates on rising edge
//   reset        in   1      asynchronous, active-low reset (0 = reset)
//   start        in   1      request; sampled only in IDLE
//   is_signed    in   1      1: two's-complement operands; sampled with start
//   a            in   WIDTH  dividend; sampled with start
//   b            in   WIDTH  divisor; sampled with start
//   quotient     out  WIDTH  registered quotient, held until next result written
//   remainder    out  WIDTH  registered remainder, held until next result written
//   busy         out  1      1 while state != IDLE
//   done         out  1      one-cycle pulse: quotient/remainder valid
//   div_by_zero  out  1      registered with done; 1 if b was 0; held until next result
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, count=0, quotient=0, remainder=0, done=0,
//     div_by_zero=0, busy=0. Reset mid-operation aborts; no done, no result written.
//   States: IDLE, CALC, FIN.
//   IDLE: start=1 at edge N -> latch a, b, mode (signed = is_signed & SIGNED_EN);
//     store |a|, |b| as WIDTH-bit unsigned magnitudes, sign of a, sign of a^b;
//     clear partial remainder and count; b==0 -> FIN (zero flag set), else -> CALC.
//   CALC: per edge: rem = {rem[W-2:0], dvd[W-1]}; dvd <<= 1; if rem >= |b| then
//     rem -= |b|, shift 1 into quotient, else 0. Partial remainder is WIDTH+1 bits
//     internally. count increments; step with count==WIDTH-1 moves to FIN.
//     Exactly WIDTH steps: edges N+1..N+WIDTH.
//   FIN: one edge writes outputs, done<=1, div_by_zero<=flag, -> IDLE.
//     Normal: edge N+WIDTH+1; done high during cycle after it (latency WIDTH+2 edges).
//     b==0: edge N+1; done visible after 2 edges.
//   done cleared on the next edge (single pulse). start in the cycle done is high is
//     accepted (state already IDLE): back-to-back throughput WIDTH+2 cycles.
//   start while busy=1: ignored, no effect on in-flight operation or operands.
//   Result rules:
//     unsigned: q = a / b, r = a % b.
//     signed: q truncates toward zero (negated if signs differ); r takes sign of a;
//       a == q*b + r always holds mod 2^WIDTH.
//     b == 0: q = all ones, r = a (unmodified, either mode), div_by_zero=1.
//     signed MIN / -1: q = MIN, r = 0 (falls out of magnitude path; no flag).
//   Magnitude of MIN is 2^(WIDTH-1), representable unsigned; no extra width needed.
//   Inputs a, b, is_signed may change freely after the start edge.
// TESTING (WIDTH=32 unless stated)
//   1 unsigned a=100, b=7, start 1 cycle -> busy 33 cycles, done pulse 34 edges after
//     start edge... q=14, r=2, div_by_zero=0; done exactly 1 cycle wide.
//   2 signed a=-7 (0xFFFFFFF9), b=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; a=7, b=-2 -> q=0xFFFFFFFD,
//     r=1; same operands with is_signed=0: a=0xFFFFFFF9,b=2 -> q=0x7FFFFFFC, r=1.
//   3 a=0x1234, b=0 (both modes) -> done 2 edges after start, q=0xFFFFFFFF, r=0x1234,
//     div_by_zero=1; following op 9/3 -> q=3, r=0, div_by_zero=0.
//   4 signed a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0, div_by_zero=0.
//   5 start 100/7, pulse start again with a=5,b=5 at step 10 -> ignored, result 14 r 2;
//     then start, drive reset=0 at step 10 -> busy=0, outputs 0 immediately, no done;
//     release, run 50/8 -> q=6, r=2.
//   6 WIDTH=8, SIGNED_EN=0: a=255, b=16, is_signed=1 -> q=15, r=15 (unsigned forced);
//     start reasserted in the done cycle with 200/3 -> accepted, q=66, r=2 after 10 edges.

Source files
------------

// File: rtl/divmod_seq.sv
// divmod_seq: restoring shift-subtract divider producing one quotient bit per
// cycle, with optional two's-complement mode and a divide-by-zero flag.
module divmod_seq #(
  parameter int WIDTH     = 32,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd, dvs, quo, rem;
  logic             neg_q, neg_r, zero_flag;
  logic             mode_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             sub_ok;

  // The magnitude of MIN is 2^(WIDTH-1), which still fits as an unsigned value.
  assign mode_signed = is_signed && (SIGNED_EN != 0);
  assign a_mag       = (mode_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag       = (mode_signed && b[WIDTH-1]) ? -b : b;
  assign busy        = (state != IDLE);

  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    sub_ok  = (shifted >= {1'b0, dvs});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (b == '0) ? FIN : CALC;
      CALC:    if (count == LAST) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // On divide-by-zero the raw dividend is parked in rem so FIN can return it unmodified.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      rem         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_flag   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd       <= a_mag;
            dvs       <= b_mag;
            quo       <= '0;
            rem       <= (b == '0) ? a : '0;
            count     <= '0;
            neg_q     <= mode_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r     <= mode_signed && a[WIDTH-1];
            zero_flag <= (b == '0);
          end
        end
        CALC: begin
          rem   <= sub_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd   <= dvd << 1;
          quo   <= {quo[WIDTH-2:0], sub_ok};
          count <= count + 1'b1;
        end
        FIN: begin
          if (zero_flag) begin
            quotient  <= '1;
            remainder <= rem;
          end else begin
            quotient  <= neg_q ? -quo : quo;
            remainder <= neg_r ? -rem : rem;
          end
          div_by_zero <= zero_flag;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
